// File: rtl/trap_ctrl.sv
// Machine-mode trap/MRET sequencer at the commit point. It arbitrates interrupts,
// exceptions and MRET, drains the pipeline, pulses the CSR file and redirects fetch.
module trap_ctrl #(
   parameter int MXLEN       = 32,
   parameter bit VECTORED_EN = 1'b1
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_inst_valid,
   input  logic [MXLEN-1:0] i_pc,
   input  logic [31:0]      i_inst,
   input  logic [MXLEN-1:0] i_addr,
   input  logic             i_exc_illegal,
   input  logic             i_exc_ecall,
   input  logic             i_exc_ebreak,
   input  logic             i_exc_ld_mis,
   input  logic             i_exc_st_mis,
   input  logic             i_mret,
   input  logic [MXLEN-1:0] i_mstatus,
   input  logic [MXLEN-1:0] i_mie,
   input  logic [MXLEN-1:0] i_mip,
   input  logic [MXLEN-1:0] i_mtvec,
   input  logic [MXLEN-1:0] i_mepc,
   input  logic             i_pipe_idle,
   input  logic             i_redirect_ack,
   output logic             o_stall,
   output logic             o_flush,
   output logic             o_trap_req,
   output logic             o_trap_mret,
   output logic [MXLEN-1:0] o_trap_cause,
   output logic [MXLEN-1:0] o_trap_tval,
   output logic [MXLEN-1:0] o_trap_pc,
   output logic [1:0]       o_priv_mode,
   output logic             o_redirect_valid,
   output logic [MXLEN-1:0] o_redirect_pc
);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_DRAIN    = 2'd1,
      ST_TRAP     = 2'd2,
      ST_REDIRECT = 2'd3
   } state_e;

   localparam logic [1:0] PRIV_U = 2'b00;
   localparam logic [1:0] PRIV_M = 2'b11;

   // state_q is the observable FSM state for checkers bound to this block.
   state_e           state_q, state_d;
   logic [1:0]       priv_q, priv_d;
   logic             is_mret_q, is_mret_d;
   logic             is_irq_q, is_irq_d;
   logic [MXLEN-1:0] cause_q, cause_d;
   logic [MXLEN-1:0] tval_q, tval_d;
   logic [MXLEN-1:0] pc_q, pc_d;
   logic [MXLEN-1:0] rpc_q, rpc_d;
   logic             stall_q, stall_d;
   logic             flush_q, flush_d;
   logic             req_q, req_d;
   logic             mret_pulse_q, mret_pulse_d;
   logic             rvalid_q, rvalid_d;

   // Redirect handshake: o_redirect_valid rises in REDIRECT and o_redirect_pc stays
   // stable until a cycle with i_redirect_ack high; that edge drops valid and stall.

   logic [MXLEN-1:0] pend;
   logic             is_u;
   logic             irq_en;
   logic             irq_any;
   logic             irq_hit;
   logic [3:0]       irq_code;
   logic             exc_hit;
   logic [3:0]       exc_code;
   logic [MXLEN-1:0] exc_tval;
   logic             mret_hit;
   logic [MXLEN-1:0] irq_cause;

   always_comb begin
      pend     = i_mip & i_mie;
      is_u     = (priv_q == PRIV_U);
      irq_en   = is_u || i_mstatus[3];
      irq_any  = 1'b0;
      irq_code = 4'd0;
      if (pend[11]) begin
         irq_any  = 1'b1;
         irq_code = 4'd11;
      end else if (pend[3]) begin
         irq_any  = 1'b1;
         irq_code = 4'd3;
      end else if (pend[7]) begin
         irq_any  = 1'b1;
         irq_code = 4'd7;
      end
      irq_hit = irq_any && irq_en;

      irq_cause            = '0;
      irq_cause[MXLEN-1]   = 1'b1;
      irq_cause[3:0]       = irq_code;
   end

   // MRET from U-mode is reported as an illegal instruction.
   always_comb begin
      exc_hit  = 1'b1;
      exc_code = 4'd0;
      exc_tval = '0;
      if (i_exc_illegal || (i_mret && is_u)) begin
         exc_code = 4'd2;
         exc_tval = MXLEN'(i_inst);
      end else if (i_exc_ebreak) begin
         exc_code = 4'd3;
      end else if (i_exc_ecall) begin
         exc_code = is_u ? 4'd8 : 4'd11;
      end else if (i_exc_ld_mis) begin
         exc_code = 4'd4;
         exc_tval = i_addr;
      end else if (i_exc_st_mis) begin
         exc_code = 4'd6;
         exc_tval = i_addr;
      end else begin
         exc_hit = 1'b0;
      end
      mret_hit = i_mret && !is_u;
   end

   logic [MXLEN-1:0] tvec_base;
   logic [MXLEN-1:0] tvec_target;
   logic [MXLEN-1:0] mret_target;
   logic [1:0]       mret_priv;

   always_comb begin
      tvec_base   = i_mtvec & ~MXLEN'(3);
      tvec_target = tvec_base;
      if (VECTORED_EN && (i_mtvec[1:0] == 2'b01) && is_irq_q) begin
         tvec_target = tvec_base + (MXLEN'(cause_q[3:0]) << 2);
      end
      mret_target = i_mepc & ~MXLEN'(3);
      // Only U and M exist here; any MPP other than M returns to U.
      mret_priv   = (i_mstatus[12:11] == PRIV_M) ? PRIV_M : PRIV_U;
   end

   always_comb begin
      state_d      = state_q;
      priv_d       = priv_q;
      is_mret_d    = is_mret_q;
      is_irq_d     = is_irq_q;
      cause_d      = cause_q;
      tval_d       = tval_q;
      pc_d         = pc_q;
      rpc_d        = rpc_q;
      stall_d      = stall_q;
      flush_d      = 1'b0;
      req_d        = 1'b0;
      mret_pulse_d = 1'b0;
      rvalid_d     = rvalid_q;

      case (state_q)
         ST_IDLE: begin
            if (i_inst_valid && (irq_hit || exc_hit || mret_hit)) begin
               state_d   = ST_DRAIN;
               stall_d   = 1'b1;
               flush_d   = 1'b1;
               pc_d      = i_pc;
               is_irq_d  = irq_hit;
               is_mret_d = !irq_hit && !exc_hit;
               if (irq_hit) begin
                  cause_d = irq_cause;
                  tval_d  = '0;
               end else if (exc_hit) begin
                  cause_d = MXLEN'(exc_code);
                  tval_d  = exc_tval;
               end else begin
                  cause_d = '0;
                  tval_d  = '0;
               end
            end
         end
         ST_DRAIN: begin
            if (i_pipe_idle) begin
               state_d      = ST_TRAP;
               req_d        = !is_mret_q;
               mret_pulse_d = is_mret_q;
               priv_d       = is_mret_q ? mret_priv : PRIV_M;
               rpc_d        = is_mret_q ? mret_target : tvec_target;
            end
         end
         ST_TRAP: begin
            state_d  = ST_REDIRECT;
            rvalid_d = 1'b1;
         end
         ST_REDIRECT: begin
            if (i_redirect_ack) begin
               state_d  = ST_IDLE;
               rvalid_d = 1'b0;
               stall_d  = 1'b0;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q      <= ST_IDLE;
         priv_q       <= PRIV_M;
         is_mret_q    <= 1'b0;
         is_irq_q     <= 1'b0;
         cause_q      <= '0;
         tval_q       <= '0;
         pc_q         <= '0;
         rpc_q        <= '0;
         stall_q      <= 1'b0;
         flush_q      <= 1'b0;
         req_q        <= 1'b0;
         mret_pulse_q <= 1'b0;
         rvalid_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         priv_q       <= priv_d;
         is_mret_q    <= is_mret_d;
         is_irq_q     <= is_irq_d;
         cause_q      <= cause_d;
         tval_q       <= tval_d;
         pc_q         <= pc_d;
         rpc_q        <= rpc_d;
         stall_q      <= stall_d;
         flush_q      <= flush_d;
         req_q        <= req_d;
         mret_pulse_q <= mret_pulse_d;
         rvalid_q     <= rvalid_d;
      end
   end

   assign o_stall          = stall_q;
   assign o_flush          = flush_q;
   assign o_trap_req       = req_q;
   assign o_trap_mret      = mret_pulse_q;
   assign o_trap_cause     = cause_q;
   assign o_trap_tval      = tval_q;
   assign o_trap_pc        = pc_q;
   assign o_priv_mode      = priv_q;
   assign o_redirect_valid = rvalid_q;
   assign o_redirect_pc    = rpc_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: directed scenarios plus randomized transactions checked
// against an arbitration/target model derived from the privileged-mode rules.
module tb_trap_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        inst_valid, exc_ill, exc_ecall, exc_ebreak, exc_ld, exc_st, mret;
   logic [31:0] pc, inst, addr, mstatus, mie, mip, mtvec, mepc;
   logic        pipe_idle, redirect_ack;
   logic        stall, flush, trap_req, trap_mret, redirect_valid;
   logic [31:0] trap_cause, trap_tval, trap_pc, redirect_pc;
   logic [1:0]  priv_mode;

   always #5 clk = ~clk;

   trap_ctrl #(.MXLEN(32), .VECTORED_EN(1'b1)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_inst_valid(inst_valid), .i_pc(pc), .i_inst(inst),
      .i_addr(addr), .i_exc_illegal(exc_ill), .i_exc_ecall(exc_ecall),
      .i_exc_ebreak(exc_ebreak), .i_exc_ld_mis(exc_ld), .i_exc_st_mis(exc_st),
      .i_mret(mret), .i_mstatus(mstatus), .i_mie(mie), .i_mip(mip), .i_mtvec(mtvec),
      .i_mepc(mepc), .i_pipe_idle(pipe_idle), .i_redirect_ack(redirect_ack),
      .o_stall(stall), .o_flush(flush), .o_trap_req(trap_req), .o_trap_mret(trap_mret),
      .o_trap_cause(trap_cause), .o_trap_tval(trap_tval), .o_trap_pc(trap_pc),
      .o_priv_mode(priv_mode), .o_redirect_valid(redirect_valid),
      .o_redirect_pc(redirect_pc)
   );

   typedef struct {
      logic        valid;
      logic [31:0] pc, inst, addr, mstatus, mie, mip, mtvec, mepc;
      logic        ill, ecall, ebreak, ld, st, mret;
   } txn_t;

   int          n_vec = 0;
   int          n_err = 0;
   logic [1:0]  m_priv;
   logic [31:0] exp_q[$];

   // Observations collected by run_txn for one transaction.
   int          o_flush_cnt, o_req_cnt, o_mret_cnt, o_stall_cnt, o_valid_cnt, o_cycles;
   logic [31:0] o_cause, o_tval, o_pc, o_rpc;
   logic [1:0]  o_priv_drain, o_priv_end;
   bit          o_rpc_stable, o_timeout, o_flush_first;

   function automatic txn_t blank_txn();
      txn_t t;
      t.valid = 1'b1; t.pc = 32'h0; t.inst = 32'h0; t.addr = 32'h0;
      t.mstatus = 32'h0; t.mie = 32'h0; t.mip = 32'h0; t.mtvec = 32'h0; t.mepc = 32'h0;
      t.ill = 1'b0; t.ecall = 1'b0; t.ebreak = 1'b0; t.ld = 1'b0; t.st = 1'b0; t.mret = 1'b0;
      return t;
   endfunction

   // Reference: what a commit of t in privilege priv should do.
   function automatic void ref_model(input txn_t t, input logic [1:0] priv,
                                     output bit take, output bit is_mret,
                                     output logic [31:0] cause, output logic [31:0] tval,
                                     output logic [31:0] target, output logic [1:0] new_priv);
      logic [31:0] pend;
      int          code;
      bit          irq;
      pend = t.mip & t.mie;
      take = 1; is_mret = 0; cause = 0; tval = 0; irq = 0; code = 0;
      if (!t.valid) take = 0;
      else if ((priv == 2'b00 || t.mstatus[3]) && (pend[11] || pend[3] || pend[7])) begin
         irq = 1;
         code = pend[11] ? 11 : (pend[3] ? 3 : 7);
         cause = 32'h8000_0000 + 32'(code);
      end
      else if (t.ill || (t.mret && priv == 2'b00)) begin cause = 2; tval = t.inst; end
      else if (t.ebreak) cause = 3;
      else if (t.ecall) cause = (priv == 2'b00) ? 8 : 11;
      else if (t.ld) begin cause = 4; tval = t.addr; end
      else if (t.st) begin cause = 6; tval = t.addr; end
      else if (t.mret) is_mret = 1;
      else take = 0;
      if (is_mret) begin
         target = t.mepc & 32'hFFFF_FFFC;
         new_priv = (t.mstatus[12:11] == 2'b11) ? 2'b11 : 2'b00;
      end else begin
         target = t.mtvec & 32'hFFFF_FFFC;
         if (irq && t.mtvec[1:0] == 2'b01) target = target + 32'(4 * code);
         new_priv = take ? 2'b11 : priv;
      end
   endfunction

   task automatic clear_inputs();
      inst_valid = 0; exc_ill = 0; exc_ecall = 0; exc_ebreak = 0; exc_ld = 0; exc_st = 0;
      mret = 0; pipe_idle = 0; redirect_ack = 0;
   endtask

   // Drives one commit and plays pipeline/fetch; only records what it observes.
   task automatic run_txn(input txn_t t, input int drain_wait, input int ack_wait);
      int drain_k, v_k;
      bit seen_stall, done;
      o_flush_cnt = 0; o_req_cnt = 0; o_mret_cnt = 0; o_stall_cnt = 0; o_valid_cnt = 0;
      o_cycles = 0; o_cause = 0; o_tval = 0; o_pc = 0; o_rpc = 0;
      o_rpc_stable = 1; o_timeout = 0; o_flush_first = 0;
      o_priv_drain = priv_mode; o_priv_end = priv_mode;
      drain_k = 0; v_k = 0; seen_stall = 0; done = 0;
      @(negedge clk);
      mstatus = t.mstatus; mie = t.mie; mip = t.mip; mtvec = t.mtvec; mepc = t.mepc;
      pc = t.pc; inst = t.inst; addr = t.addr; inst_valid = t.valid;
      exc_ill = t.ill; exc_ecall = t.ecall; exc_ebreak = t.ebreak;
      exc_ld = t.ld; exc_st = t.st; mret = t.mret; pipe_idle = 0; redirect_ack = 0;
      for (int c = 1; c <= 60 && !done; c++) begin
         @(negedge clk);
         o_cycles = c;
         if (stall) begin
            inst_valid = 1'($urandom_range(0, 1)); exc_ill = 1'($urandom_range(0, 1));
            exc_ecall = 1'($urandom_range(0, 1)); exc_ebreak = 1'($urandom_range(0, 1));
            exc_ld = 1'($urandom_range(0, 1)); exc_st = 1'($urandom_range(0, 1));
            mret = 1'($urandom_range(0, 1));
            pc = $urandom(); inst = $urandom(); addr = $urandom();
            pipe_idle = 1'($urandom_range(0, 1)); redirect_ack = 0;
            if (!seen_stall) o_priv_drain = priv_mode;
            seen_stall = 1;
            o_stall_cnt++;
            if (flush) begin
               o_flush_cnt++;
               if (o_stall_cnt == 1) o_flush_first = 1;
            end
            if (trap_req || trap_mret) begin
               o_req_cnt += int'(trap_req); o_mret_cnt += int'(trap_mret);
               o_cause = trap_cause; o_tval = trap_tval; o_pc = trap_pc;
            end
            if (redirect_valid) begin
               v_k++; o_valid_cnt++;
               if (v_k == 1) o_rpc = redirect_pc;
               else if (redirect_pc !== o_rpc) o_rpc_stable = 0;
               redirect_ack = (v_k == ack_wait + 1);
            end else if (!(trap_req || trap_mret) && (o_req_cnt + o_mret_cnt) == 0) begin
               drain_k++;
               pipe_idle = (drain_k > drain_wait);
            end
         end else begin
            o_flush_cnt += int'(flush); o_req_cnt += int'(trap_req);
            o_mret_cnt += int'(trap_mret); o_valid_cnt += int'(redirect_valid);
            clear_inputs();
            if (seen_stall || c >= 3) begin
               done = 1;
               o_priv_end = priv_mode;
            end
         end
      end
      if (!done) o_timeout = 1;
      clear_inputs();
   endtask

   task automatic test_reset();
      clear_inputs();
      pc = 0; inst = 0; addr = 0; mstatus = 0; mie = 0; mip = 0; mtvec = 0; mepc = 0;
      rst_n = 0;
      repeat (2) @(negedge clk);
      n_vec++;
      if (priv_mode !== 2'b11) begin
         n_err++; $display("FAIL reset_priv got %b exp 11", priv_mode);
      end
      n_vec++;
      if ({stall, flush, trap_req, trap_mret, redirect_valid, trap_cause, trap_tval, trap_pc,
           redirect_pc} !== '0) begin
         n_err++; $display("FAIL reset_outputs got nonzero, exp all zero (stall=%b cause=%h)",
                           stall, trap_cause);
      end
      rst_n = 1;
      m_priv = 2'b11;
   endtask

   task automatic test_irq_vectored();
      txn_t t;
      t = blank_txn();
      t.mstatus = 32'h8; t.mie = 32'h880; t.mip = 32'h880; t.mtvec = 32'h101; t.pc = 32'h2000;
      run_txn(t, 0, 0);
      n_vec++;
      if (o_timeout || o_req_cnt !== 1) begin
         n_err++; $display("FAIL irq_req_pulses got %0d exp 1 (timeout=%0b)", o_req_cnt, o_timeout);
      end
      n_vec++;
      if (o_cause !== 32'h8000_000B) begin n_err++; $display("FAIL irq_cause got %h exp 8000000b", o_cause); end
      n_vec++;
      if (o_pc !== 32'h2000 || o_tval !== 0) begin
         n_err++; $display("FAIL irq_pc_tval got %h/%h exp 00002000/00000000", o_pc, o_tval);
      end
      n_vec++;
      if (o_rpc !== 32'h12C) begin n_err++; $display("FAIL irq_redirect got %h exp 0000012c", o_rpc); end
      n_vec++;
      if (o_cycles !== 4) begin n_err++; $display("FAIL min_sequence cycles got %0d exp 4", o_cycles); end
      m_priv = 2'b11;
   endtask

   task automatic test_mret(input logic [1:0] mpp, input logic [31:0] epc);
      txn_t t;
      t = blank_txn();
      t.mret = 1; t.mstatus = {19'b0, mpp, 11'b0}; t.mepc = epc; t.pc = 32'h3000;
      run_txn(t, 0, 0);
      n_vec++;
      if (o_timeout || o_mret_cnt !== 1 || o_req_cnt !== 0) begin
         n_err++; $display("FAIL mret_pulses mpp=%b got mret=%0d req=%0d exp 1/0", mpp, o_mret_cnt, o_req_cnt);
      end
      n_vec++;
      if (o_priv_end !== 2'b00) begin n_err++; $display("FAIL mret_priv mpp=%b got %b exp 00", mpp, o_priv_end); end
      n_vec++;
      if (o_rpc !== (epc & 32'hFFFF_FFFC)) begin
         n_err++; $display("FAIL mret_redirect got %h exp %h", o_rpc, epc & 32'hFFFF_FFFC);
      end
      m_priv = 2'b00;
   endtask

   task automatic test_u_ecall();
      txn_t t;
      t = blank_txn();
      t.ecall = 1; t.ld = 1; t.addr = 32'h33; t.mtvec = 32'h100; t.pc = 32'h5000;
      run_txn(t, 0, 0);
      n_vec++;
      if (o_timeout || o_req_cnt !== 1 || o_cause !== 32'd8 || o_tval !== 0) begin
         n_err++; $display("FAIL u_ecall got req=%0d cause=%h tval=%h exp 1/00000008/00000000", o_req_cnt, o_cause, o_tval);
      end
      n_vec++;
      if (o_priv_drain !== 2'b00 || o_priv_end !== 2'b11) begin
         n_err++; $display("FAIL u_ecall_priv got %b->%b exp 00->11", o_priv_drain, o_priv_end);
      end
      n_vec++;
      if (o_rpc !== 32'h100) begin n_err++; $display("FAIL u_ecall_redirect got %h exp 00000100", o_rpc); end
      m_priv = 2'b11;
   endtask

   task automatic test_u_mret_illegal();
      txn_t t;
      t = blank_txn();
      t.mret = 1; t.inst = 32'h3020_0073; t.mtvec = 32'h200; t.mepc = 32'h7000;
      t.mstatus = 32'h1800;
      run_txn(t, 0, 0);
      n_vec++;
      if (o_timeout || o_mret_cnt !== 0 || o_req_cnt !== 1) begin
         n_err++; $display("FAIL u_mret_pulses got mret=%0d req=%0d exp 0/1", o_mret_cnt, o_req_cnt);
      end
      n_vec++;
      if (o_cause !== 32'd2 || o_tval !== 32'h3020_0073 || o_rpc !== 32'h200) begin
         n_err++; $display("FAIL u_mret_illegal got cause=%h tval=%h rpc=%h exp 00000002/30200073/00000200", o_cause, o_tval, o_rpc);
      end
      m_priv = 2'b11;
   endtask

   task automatic test_irq_masked();
      txn_t t;
      t = blank_txn();
      t.mie = 32'h80; t.mip = 32'h80; t.mtvec = 32'h101; t.pc = 32'h6000;
      run_txn(t, 0, 0);
      n_vec++;
      if (o_timeout || o_stall_cnt !== 0 || o_req_cnt !== 0) begin
         n_err++; $display("FAIL masked_irq got stall=%0d req=%0d exp 0/0", o_stall_cnt, o_req_cnt);
      end
      test_mret(2'b00, 32'h4000);
      run_txn(t, 0, 0);
      n_vec++;
      if (o_timeout || o_req_cnt !== 1 || o_cause !== 32'h8000_0007 || o_pc !== 32'h6000) begin
         n_err++; $display("FAIL u_irq got req=%0d cause=%h pc=%h exp 1/80000007/00006000", o_req_cnt, o_cause, o_pc);
      end
      n_vec++;
      if (o_rpc !== 32'h11C) begin n_err++; $display("FAIL u_irq_redirect got %h exp 0000011c", o_rpc); end
      m_priv = 2'b11;
   endtask

   task automatic test_slow_handshake();
      txn_t t;
      t = blank_txn();
      t.ebreak = 1; t.mtvec = 32'h300; t.pc = 32'h8000;
      run_txn(t, 5, 3);
      n_vec++;
      if (o_flush_cnt !== 1 || !o_flush_first) begin
         n_err++; $display("FAIL slow_flush got %0d cycles (first=%0b) exp 1", o_flush_cnt, o_flush_first);
      end
      n_vec++;
      if (o_timeout || o_stall_cnt !== 11 || o_valid_cnt !== 4) begin
         n_err++; $display("FAIL slow_stall got stall=%0d valid=%0d exp 11/4", o_stall_cnt, o_valid_cnt);
      end
      n_vec++;
      if (!o_rpc_stable || o_rpc !== 32'h300 || o_req_cnt !== 1 || o_cause !== 32'd3) begin
         n_err++; $display("FAIL slow_redirect got rpc=%h stable=%0b req=%0d cause=%h exp 00000300/1/1/00000003", o_rpc, o_rpc_stable, o_req_cnt, o_cause);
      end
      m_priv = 2'b11;
   endtask

   task automatic test_reset_in_drain();
      int reqs, stalls;
      test_mret(2'b00, 32'h4000);
      @(negedge clk);
      mtvec = 32'h100; mie = 0; mip = 0; mstatus = 0;
      inst_valid = 1; exc_ecall = 1; pipe_idle = 0;
      @(negedge clk);
      clear_inputs();
      n_vec++;
      if (stall !== 1'b1) begin n_err++; $display("FAIL drain_entry stall got %b exp 1", stall); end
      #2 rst_n = 0;
      #1;
      n_vec++;
      if (priv_mode !== 2'b11 || stall !== 1'b0 || flush !== 1'b0) begin
         n_err++; $display("FAIL drain_reset got priv=%b stall=%b flush=%b exp 11/0/0", priv_mode, stall, flush);
      end
      @(negedge clk);
      rst_n = 1; pipe_idle = 1; redirect_ack = 1;
      reqs = 0; stalls = 0;
      repeat (6) begin
         @(negedge clk);
         reqs += int'(trap_req) + int'(trap_mret);
         stalls += int'(stall) + int'(redirect_valid);
      end
      clear_inputs();
      n_vec++;
      if (reqs !== 0 || stalls !== 0 || priv_mode !== 2'b11) begin
         n_err++; $display("FAIL post_reset got pulses=%0d busy=%0d priv=%b exp 0/0/11", reqs, stalls, priv_mode);
      end
      m_priv = 2'b11;
   endtask

   task automatic test_random(input int n);
      txn_t        t;
      bit          take, is_mret;
      logic [31:0] e_cause, e_tval, e_target, got_target;
      logic [1:0]  e_priv;
      int          dw, aw;
      for (int i = 0; i < n; i++) begin
         t = blank_txn();
         t.valid = ($urandom_range(0, 7) != 0);
         t.pc = $urandom(); t.inst = $urandom(); t.addr = $urandom();
         t.mstatus = $urandom(); t.mtvec = $urandom(); t.mepc = $urandom();
         t.mie = $urandom_range(0, 4095); t.mip = $urandom_range(0, 4095) & $urandom_range(0, 4095);
         t.ill = ($urandom_range(0, 5) == 0); t.ecall = ($urandom_range(0, 3) == 0);
         t.ebreak = ($urandom_range(0, 5) == 0); t.ld = ($urandom_range(0, 3) == 0);
         t.st = ($urandom_range(0, 3) == 0); t.mret = ($urandom_range(0, 2) == 0);
         dw = $urandom_range(0, 3); aw = $urandom_range(0, 2);
         ref_model(t, m_priv, take, is_mret, e_cause, e_tval, e_target, e_priv);
         if (take) exp_q.push_back(e_target);
         run_txn(t, dw, aw);
         n_vec++;
         if (o_timeout || o_stall_cnt !== (take ? dw + aw + 3 : 0) || o_flush_cnt !== int'(take)) begin
            n_err++; $display("FAIL rnd%0d_seq got stall=%0d flush=%0d exp %0d/%0d", i, o_stall_cnt, o_flush_cnt, take ? dw + aw + 3 : 0, int'(take));
         end
         n_vec++;
         if (o_req_cnt !== int'(take && !is_mret) || o_mret_cnt !== int'(is_mret)) begin
            n_err++; $display("FAIL rnd%0d_pulse got req=%0d mret=%0d exp %0d/%0d", i, o_req_cnt, o_mret_cnt, int'(take && !is_mret), int'(is_mret));
         end
         if (take && !is_mret) begin
            n_vec++;
            if (o_cause !== e_cause || o_tval !== e_tval || o_pc !== t.pc) begin
               n_err++; $display("FAIL rnd%0d_csr got %h/%h/%h exp %h/%h/%h", i, o_cause, o_tval, o_pc, e_cause, e_tval, t.pc);
            end
         end
         if (take) begin
            got_target = exp_q.pop_front();
            n_vec++;
            if (o_rpc !== got_target || !o_rpc_stable) begin
               n_err++; $display("FAIL rnd%0d_redirect got %h exp %h", i, o_rpc, got_target);
            end
         end
         n_vec++;
         if (o_priv_end !== e_priv) begin
            n_err++; $display("FAIL rnd%0d_priv got %b exp %b", i, o_priv_end, e_priv);
         end
         m_priv = e_priv;
      end
   endtask

   initial begin
      test_reset();
      test_irq_vectored();
      test_mret(2'b00, 32'h4000);
      test_u_ecall();
      test_mret(2'b10, 32'h4002);
      test_u_mret_illegal();
      test_irq_masked();
      test_slow_handshake();
      test_reset_in_drain();
      test_random(150);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout got no finish exp finish before 2ms");
      $fatal(1, "timeout");
   end

endmodule
